l1_mem_port_arbiter: RTL and testbench

//  Shares one downstream memory port between the instruction-fetch side and the

---
 rtl/l1_mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_l1_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_port_arbiter.sv
// Arbitrates one downstream memory port between instruction fetch and data access.
// One transaction in flight at a time; data side wins unless fetch has starved.
module l1_mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_rd_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rd_data,
    output logic                i_stall,
    input  logic                d_rd_en,
    input  logic                d_wr_en,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wr_mask,
    input  logic [DATA_W-1:0]   d_wr_data,
    output logic [DATA_W-1:0]   d_rd_data,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] i_rd_q, i_rd_d;
    logic [DATA_W-1:0] d_rd_q, d_rd_d;

    logic d_pend, pick_i, done;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        cmd_d    = cmd_q;
        i_rd_d   = i_rd_q;
        d_rd_d   = d_rd_q;
        d_pend   = d_rd_en | d_wr_en;
        pick_i   = i_rd_en && (!d_pend || starve_q == CNT_MAX);
        case (state_q)
            IDLE: begin
                if (i_rd_en || d_pend) begin
                    state_d = ISSUE;
                    if (pick_i) begin
                        owner_d     = OWN_I;
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = i_addr;
                        cmd_d.mask  = '0;
                        cmd_d.wdata = '0;
                        starve_d    = '0;
                    end else begin
                        owner_d     = OWN_D;
                        cmd_d.we    = d_wr_en;
                        cmd_d.addr  = d_addr;
                        cmd_d.mask  = d_wr_mask;
                        cmd_d.wdata = d_wr_data;
                        // Count only grants that made a waiting fetch wait longer.
                        if (!i_rd_en)
                            starve_d = '0;
                        else if (starve_q != CNT_MAX)
                            starve_d = starve_q + 1'b1;
                    end
                end
            end
            ISSUE: if (mem_gnt) state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    if (owner_q == OWN_I)
                        i_rd_d = mem_rdata;
                    else if (!cmd_q.we)
                        d_rd_d = mem_rdata;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            starve_q <= '0;
            cmd_q    <= '0;
            i_rd_q   <= '0;
            d_rd_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            cmd_q    <= cmd_d;
            i_rd_q   <= i_rd_d;
            d_rd_q   <= d_rd_d;
        end
    end

    assign done      = (state_q == DONE);
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wmask = cmd_q.mask;
    assign mem_wdata = cmd_q.wdata;
    assign i_rd_data = i_rd_q;
    assign d_rd_data = d_rd_q;
    // A side that dropped its request never stalls, even if its access is in flight.
    assign i_stall   = i_rd_en && !(done && owner_q == OWN_I);
    assign d_stall   = d_pend && !(done && owner_q == OWN_D);
endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Bench for l1_mem_port_arbiter: transaction-level model tracked per cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l1_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_rd_en = 0, d_rd_en = 0, d_wr_en = 0;
    logic [ADDR_W-1:0] i_addr = 0, d_addr = 0;
    logic [3:0]        d_wr_mask = 0;
    logic [DATA_W-1:0] d_wr_data = 0;
    logic [DATA_W-1:0] i_rd_data, d_rd_data;
    logic              i_stall, d_stall;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt = 0, mem_rvalid = 0;
    logic [DATA_W-1:0] mem_rdata = 0;

    l1_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(rst),
        .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_stall(i_stall),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_mask(d_wr_mask),
        .d_wr_data(d_wr_data), .d_rd_data(d_rd_data), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the one transaction in flight and which protocol events it has seen.
    bit              m_busy, m_gnt, m_resp, m_own_d, m_we;
    logic [31:0]     m_addr, m_wdata, m_ird, m_drd;
    logic [3:0]      m_mask;
    int              m_starve, req_cnt, rv_cnt;

    // Responder controls
    bit              rmode = 0, stray = 0;
    int              gnt_wait = 0, rv_wait = 0;
    logic [31:0]     rdata_val = 0;

    // Values sampled in the last tick
    logic            s_i_stall, s_d_stall, s_mem_req, s_mem_we;
    logic [31:0]     s_mem_addr, s_i_rd, s_d_rd;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_resp = 0; m_own_d = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_mask = 0; m_ird = 0; m_drd = 0;
        m_starve = 0; req_cnt = 0; rv_cnt = 0;
    endtask

    task automatic model_step();
        bit d_p, take_i;
        d_p = d_rd_en | d_wr_en;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (i_rd_en || d_p) begin
                take_i = i_rd_en && (!d_p || m_starve == LIMIT);
                m_busy = 1; m_gnt = 0; m_resp = 0; req_cnt = 0; rv_cnt = 0;
                if (take_i) begin
                    m_own_d = 0; m_we = 0; m_addr = i_addr; m_starve = 0;
                end else begin
                    m_own_d = 1; m_we = d_wr_en; m_addr = d_addr;
                    m_mask = d_wr_mask; m_wdata = d_wr_data;
                    m_starve = i_rd_en ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
                end
            end
        end else if (!m_gnt) begin
            if (mem_gnt) m_gnt = 1; else req_cnt++;
        end else if (!m_resp) begin
            if (mem_rvalid) begin
                m_resp = 1;
                if (!m_own_d) m_ird = mem_rdata;
                else if (!m_we) m_drd = mem_rdata;
            end else rv_cnt++;
        end else begin
            m_busy = 0; m_gnt = 0; m_resp = 0;
        end
    endtask

    task automatic tick();
        bit e_req;
        if (rst) model_reset();
        if (stray) begin
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_0000;
        end else if (rmode) begin
            mem_gnt    = ($urandom_range(0, 2) == 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
        end else begin
            mem_gnt    = m_busy && !m_gnt && req_cnt >= gnt_wait;
            mem_rvalid = m_gnt && !m_resp && rv_cnt >= rv_wait;
            mem_rdata  = rdata_val;
        end
        #1;
        s_i_stall = i_stall; s_d_stall = d_stall; s_mem_req = mem_req; s_mem_we = mem_we;
        s_mem_addr = mem_addr; s_i_rd = i_rd_data; s_d_rd = d_rd_data;
        e_req = m_busy && !m_gnt;
        chk("mem_req", mem_req, e_req);
        chk("i_stall", i_stall, i_rd_en && !(m_resp && !m_own_d));
        chk("d_stall", d_stall, (d_rd_en || d_wr_en) && !(m_resp && m_own_d));
        chk("i_rd_data", i_rd_data, m_ird);
        chk("d_rd_data", d_rd_data, m_drd);
        if (e_req) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) begin
                chk("mem_wmask", mem_wmask, m_mask);
                chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, td, ti, nreq, nd, ic;
        bit prev;
        model_reset();
        @(negedge clk);
        rst = 1;
        tick(); tick();
        chk("reset_mem_req", s_mem_req, 0);
        chk("reset_i_rd", s_i_rd, 0);
        rst = 0;
        tick();

        // Fetch only, immediate gnt/rvalid
        i_rd_en = 1; i_addr = 32'h100; rdata_val = 32'hDEADBEEF;
        lat = -1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t == 0) chk("fetch_stall_n", s_i_stall, 1);
            if (t == 1) chk("fetch_addr", s_mem_addr, 32'h100);
            if (!s_i_stall) begin lat = t; break; end
        end
        i_rd_en = 0;
        chk("fetch_lat", lat, 3);
        chk("fetch_data", s_i_rd, 32'hDEADBEEF);
        tick();

        // Simultaneous fetch and data read: data first
        i_rd_en = 1; i_addr = 32'h200; d_rd_en = 1; d_addr = 32'h300; rdata_val = 32'h1111_2222;
        td = -1; ti = -1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t == 1) chk("sim_first_addr", s_mem_addr, 32'h300);
            if (t == 5) chk("sim_second_addr", s_mem_addr, 32'h200);
            if (!s_d_stall && td < 0) begin td = t; d_rd_en = 0; end
            if (!s_i_stall) begin ti = t; break; end
        end
        i_rd_en = 0;
        chk("sim_d_lat", td, 3);
        chk("sim_i_lat", ti, 7);
        tick();

        // Data write with gnt delayed 3 cycles
        d_wr_en = 1; d_addr = 32'h40; d_wr_mask = 4'b0011; d_wr_data = 32'h1234_5678; gnt_wait = 3;
        nreq = 0; lat = -1;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (s_mem_req) nreq++;
            if (t == 2) chk("wr_we", s_mem_we, 1);
            if (!s_d_stall) begin lat = t; break; end
        end
        d_wr_en = 0; gnt_wait = 0;
        chk("wr_req_cycles", nreq, 4);
        chk("wr_lat", lat, 6);
        chk("wr_d_rd_keep", s_d_rd, 32'h1111_2222);
        tick();

        // Starvation guard: data back-to-back, fetch waiting
        i_rd_en = 1; i_addr = 32'h500; d_rd_en = 1; d_addr = 32'h600;
        nd = 0; ic = 0; prev = 0;
        for (int t = 0; t < 80; t++) begin
            tick();
            if (s_mem_req && !prev) begin
                if (s_mem_addr == 32'h600) nd++;
                else begin
                    ic++;
                    if (ic == 1) chk("starve_run1", nd, 4);
                    else chk("starve_run2", nd, 4);
                    nd = 0;
                end
            end
            prev = s_mem_req;
            if (ic == 2) break;
        end
        chk("starve_i_grants", ic, 2);
        i_rd_en = 0; d_rd_en = 0;
        for (int t = 0; t < 10 && m_busy; t++) tick();

        // Reset while waiting for the response, then a stray rvalid
        i_rd_en = 1; i_addr = 32'h700; rv_wait = 100;
        for (int t = 0; t < 10; t++) begin tick(); if (m_gnt) break; end
        rst = 1; i_rd_en = 0;
        tick();
        chk("rst_req_async", s_mem_req, 0);
        tick();
        rst = 0; stray = 1; rv_wait = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rst_stray_req", s_mem_req, 0);
        end
        stray = 0;
        chk("rst_i_rd", s_i_rd, 0);
        chk("rst_d_rd", s_d_rd, 0);
        tick();

        // Fetch request dropped while waiting for the response
        i_rd_en = 1; i_addr = 32'h800; rdata_val = 32'hCAFE_F00D; rv_wait = 2;
        for (int t = 0; t < 10; t++) begin tick(); if (m_gnt) break; end
        i_rd_en = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("drop_i_stall", s_i_stall, 0);
            if (!m_busy) break;
        end
        rv_wait = 0;
        chk("drop_data", s_i_rd, 32'hCAFE_F00D);
        d_rd_en = 1; d_addr = 32'h900; rdata_val = 32'h0BAD_CAFE; lat = -1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (!s_d_stall) begin lat = t; break; end
        end
        d_rd_en = 0;
        chk("after_drop_lat", lat, 3);
        chk("after_drop_data", s_d_rd, 32'h0BAD_CAFE);
        tick();

        // Randomized traffic with random gnt/rvalid, strays and rare resets
        rmode = 1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) i_rd_en = ~i_rd_en;
            if ($urandom_range(0, 7) == 0) begin
                if (d_rd_en || d_wr_en) begin d_rd_en = 0; d_wr_en = 0; end
                else begin d_rd_en = $urandom_range(0, 1); d_wr_en = $urandom_range(0, 1); end
            end
            if (!i_rd_en) i_addr = $urandom;
            if (!(d_rd_en || d_wr_en)) begin
                d_addr = $urandom; d_wr_data = $urandom; d_wr_mask = 4'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0; rmode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
